// File: rtl/multi_channel_delay_generator_pkg.sv
// Shared encodings for the multi-channel delay generator.
// Modes, channel FSM states and default LFSR constants.
package multi_channel_delay_generator_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_BLOCK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_GRANT = 2'b10
  } state_e;

  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [31:0] SEED_W8  = 32'h0000_00E1;
  localparam logic [31:0] SEED_W16 = 32'h0000_ACE1;
  localparam logic [31:0] SEED_W32 = 32'hACE1_ACE1;

  function automatic logic [31:0] default_taps(input int w);
    unique case (1'b1)
      (w == 8):  return TAPS_W8;
      (w == 32): return TAPS_W32;
      default:   return TAPS_W16;
    endcase
  endfunction

  function automatic logic [31:0] default_seed(input int w);
    unique case (1'b1)
      (w == 8):  return SEED_W8;
      (w == 32): return SEED_W32;
      default:   return SEED_W16;
    endcase
  endfunction

endpackage

// File: rtl/multi_channel_delay_generator_galois_lfsr.sv
// Reseedable Galois LFSR shared by all delay channels.
// An all-zero load falls back to SEED so the register never locks up.
module galois_lfsr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == '0) ? SEED : load_value;
    end else if (state[0]) begin
      state <= (state >> 1) ^ TAPS;
    end else begin
      state <= state >> 1;
    end
  end

endmodule

// File: rtl/multi_channel_delay_generator.sv
// Per-channel request/grant latency injector.
// Each channel samples its delay at acceptance and grants for one cycle.
module multi_channel_delay_generator
  import multi_channel_delay_generator_pkg::*;
#(
  parameter int                NR_CH   = 2,
  parameter int                LFSR_W  = 16,
  parameter int                DELAY_W = 8,
  parameter logic [LFSR_W-1:0] TAPS    =
    LFSR_W'(default_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] SEED    =
    LFSR_W'(default_seed(LFSR_W))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR_CH-1:0]     req,
  output logic [NR_CH-1:0]     gnt,
  output logic [NR_CH-1:0]     busy,
  input  logic [2*NR_CH-1:0]   cfg_mode,
  input  logic [DELAY_W-1:0]   cfg_fixed,
  input  logic [DELAY_W-1:0]   cfg_min,
  input  logic [DELAY_W-1:0]   cfg_mask,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_value
);

  logic [LFSR_W-1:0] lfsr;

  galois_lfsr #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (seed_load),
    .load_value (seed_value),
    .state      (lfsr)
  );

  for (genvar c = 0; c < NR_CH; c++) begin : g_ch
    localparam int SH = (c * DELAY_W) % LFSR_W;

    mode_e              mode;
    state_e             st_q, st_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] rnd;
    logic [DELAY_W:0]   sum;
    logic [DELAY_W-1:0] dly;

    assign mode = mode_e'(cfg_mode[2*c +: 2]);

    // Channel view of the LFSR: rotated right so channels decorrelate
    for (genvar b = 0; b < DELAY_W; b++) begin : g_rot
      assign rnd[b] = lfsr[(b + SH) % LFSR_W];
    end

    assign sum = {1'b0, cfg_min} + {1'b0, rnd & cfg_mask};

    always_comb begin
      dly = '0;
      unique case (mode)
        MODE_FIXED:  dly = cfg_fixed;
        MODE_RANDOM: dly = sum[DELAY_W] ? '1 : sum[DELAY_W-1:0];
        default:     dly = '0;
      endcase
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        ST_IDLE: begin
          if (req[c] && mode != MODE_BLOCK) begin
            cnt_d = dly;
            st_d  = (dly == '0) ? ST_GRANT : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!req[c]) begin
            st_d = ST_IDLE;
          end else if (cnt_q == DELAY_W'(1)) begin
            st_d = ST_GRANT;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
        ST_GRANT: st_d = ST_IDLE;
        default:  st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign gnt[c]  = (st_q == ST_GRANT);
    assign busy[c] = (st_q != ST_IDLE);
  end

endmodule
